alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter and sequencer that shares one 8-bit ADD/SUB ALU among `NREQ` requesters. Each requester submits an operation (a, b, opcode) over a valid/ready handshake; the arbiter grants one, drives the ALU from registered operands, captures the result and returns it on a per-requester response handshake. It sits between the client blocks and the combinational ALU (00 = ADD, 01 = SUB, others yield 0).

## Interface
- `NREQ`, 4: number of requesters (2..8)
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NREQ  request valid per requester
- `req_ready`  out  NREQ  request accepted (one-hot or zero)
- `req_a`  in  8*NREQ  operand A, requester i at [8i+7:8i]
- `req_b`  in  8*NREQ  operand B, same packing
- `req_op`  in  2*NREQ  opcode, requester i at [2i+1:2i]
- `alu_a`  out  8  registered operand A to ALU
- `alu_b`  out  8  registered operand B to ALU
- `alu_opcode`  out  2  registered opcode to ALU
- `alu_result`  in  8  ALU result (combinational from alu_a/b/opcode)
- `rsp_valid`  out  NREQ  response valid, one-hot or zero
- `rsp_data`  out  8  result for the requester flagged in rsp_valid
- `rsp_ready`  in  NREQ  response accepted per requester
- `busy`  out  1  high whenever state != IDLE
- `op_count`  out  16  completed-operation counter (see Configuration)

## Operation
- FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE: winner = first i with req_valid[i] searching from (last_grant+1) mod NREQ upward, wrapping. req_ready[winner] = 1 combinationally, all other bits 0; no valid -> req_ready = 0, stay IDLE. On handshake: latch req_a/b/op of winner into alu_a/alu_b/alu_opcode, grant <= winner, -> EXEC.
- EXEC: ALU evaluates registered operands; rsp_data <= alu_result at cycle end; -> RESP.
- RESP: rsp_valid[grant] = 1, rsp_data held. On rsp_ready[grant]: last_grant <= grant, op_count increments, -> IDLE. rsp_ready of other requesters ignored.
- Arithmetic: 8-bit, modulo 2^8, no carry/borrow output (0xFF+0x01 = 0x00, 0x00-0x01 = 0xFF). Opcodes 10/11 pass through; result 0x00, response still issued.
- req_ready is 0 outside IDLE; requests wait with req_valid held. A requester dropping req_valid before grant is simply not considered.
- Operand registers hold last values in IDLE (no toggling).
- Reset (asynchronous, any state, including mid-EXEC/RESP): state IDLE, last_grant = NREQ-1 (requester 0 highest first priority), grant 0, alu_a/alu_b/alu_opcode 0, rsp_data 0x00, rsp_valid 0, op_count 0, busy 0; req_ready forced 0 while rst_n low. In-flight operation is discarded, no response.

## Timing
- Handshake accepted at edge T (end of IDLE cycle); alu_* valid after T; rsp_data/rsp_valid valid after T+1 edge, i.e. response visible in cycle 2 after acceptance.
- rsp_ready high on first RESP cycle -> IDLE next cycle, new acceptance possible that cycle: minimum 3 cycles per operation.
- Fairness: with all requesters continuously valid, grants follow 0,1,...,NREQ-1,0,...; no requester waits more than NREQ-1 other operations.
- Response back-pressure stalls arbiter indefinitely in RESP; rsp_data stable throughout.

## Configuration
- `ALU_ARB_PERF_EN` defined: op_count is a 16-bit saturating counter of completed responses (holds at 0xFFFF), reset to 0.
- Not defined: op_count tied to 0x0000, counter logic absent; all other behaviour identical.

## Test plan
- Reset then req 0: a=0x12, b=0x34, op=00, rsp_ready=1 -> req_ready[0] same cycle, rsp_valid[0] with rsp_data=0x46 two cycles later, busy high for 2 cycles.
- Wrap: req 2 a=0xFF,b=0x01,op=00 -> 0x00; req 1 a=0x00,b=0x01,op=01 -> 0xFF; op=10 with a=0x55,b=0x11 -> 0x00.
- All 4 requesters valid continuously -> grant order 0,1,2,3,0; each response on correct rsp_valid bit with its own operands' result.
- Hold rsp_ready[grant]=0 for 5 cycles, assert rsp_ready of other requesters -> rsp_valid and rsp_data stable, req_ready stays 0, no advance until correct rsp_ready.
- Assert rst_n low during EXEC -> all outputs at reset values immediately; after release, no stale response; next grant goes to requester 0 if valid.
- With ALU_ARB_PERF_EN: 3 completed ops -> op_count=3; without macro -> op_count=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one 8-bit ADD/SUB ALU among NREQ clients.
// Define ALU_ARB_PERF_EN to enable the saturating op_count counter.
module alu_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  input  logic [2*NREQ-1:0] req_op,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [1:0]        alu_opcode,
  input  logic [7:0]        alu_result,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_data,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic              busy,
  output logic [15:0]       op_count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [7:0]    a_q, a_d;
  logic [7:0]    b_q, b_d;
  logic [1:0]    op_q, op_d;
  logic [7:0]    rsp_q, rsp_d;
  logic [IW-1:0] win;
  logic          found;
  logic          acc;
  logic          done;

  // Search starts one past the last served requester, wrapping.
  always_comb begin
    int j;
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(last_q) + k) % NREQ;
      if (!found && req_valid[IW'(j)]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end

  assign acc  = (state_q == IDLE) && found;
  assign done = (state_q == RESP) && rsp_ready[grant_q];

  assign req_ready = (acc && rst_n) ? (NREQ'(1) << win) : '0;
  assign rsp_valid = (state_q == RESP) ? (NREQ'(1) << grant_q) : '0;

  assign busy       = (state_q != IDLE);
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;
  assign rsp_data   = rsp_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rsp_d   = rsp_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          a_d     = req_a[8*int'(win) +: 8];
          b_d     = req_b[8*int'(win) +: 8];
          op_d    = req_op[2*int'(win) +: 2];
          grant_d = win;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_d   = alu_result;
        state_d = RESP;
      end
      RESP: begin
        if (done) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= IW'(NREQ - 1);
      grant_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rsp_q   <= rsp_d;
    end
  end

`ifdef ALU_ARB_PERF_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (done && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign op_count = cnt_q;
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the side.
// Expected results are hand-computed constants.
module tb_alu_arbiter;

  localparam int NREQ = 4;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [2*NREQ-1:0] req_op;
  logic [7:0]        alu_a;
  logic [7:0]        alu_b;
  logic [1:0]        alu_opcode;
  logic [7:0]        alu_result;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_data;
  logic [NREQ-1:0]   rsp_ready;
  logic              busy;
  logic [15:0]       op_count;

  int n_chk;
  int n_pass;
  int n_ops;

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy),
    .op_count  (op_count)
  );

  // External combinational ALU
  always_comb begin
    alu_result = 8'h00;
    if (alu_opcode == 2'b00) alu_result = alu_a + alu_b;
    if (alu_opcode == 2'b01) alu_result = alu_a - alu_b;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Single isolated op; entered just after a rising edge in IDLE.
  task automatic run_op(input int idx,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [1:0] op,
                        input logic [7:0] exp,
                        input string tag);
    req_a[8*idx +: 8] = a;
    req_b[8*idx +: 8] = b;
    req_op[2*idx +: 2] = op;
    req_valid[idx] = 1'b1;
    @(negedge clk);
    chk({tag, ".rdy"}, 32'(req_ready), 32'(1 << idx));
    chk({tag, ".idle"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1 req_valid[idx] = 1'b0;
    @(negedge clk);
    chk({tag, ".busy_ex"}, 32'(busy), 32'd1);
    chk({tag, ".alu_a"}, 32'(alu_a), 32'(a));
    chk({tag, ".nrsp_ex"}, 32'(rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".busy_rs"}, 32'(busy), 32'd1);
    chk({tag, ".rsp_v"}, 32'(rsp_valid), 32'(1 << idx));
    chk({tag, ".rsp_d"}, 32'(rsp_data), 32'(exp));
    @(posedge clk);
    #1;
    n_ops++;
  endtask

  logic [7:0] fa [4];
  logic [7:0] fb [4];
  logic [1:0] fo [4];
  logic [7:0] fr [4];

  initial begin
    n_chk = 0;
    n_pass = 0;
    n_ops = 0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = '1;
    rst_n = 1'b0;
    fa = '{8'h01, 8'h11, 8'h21, 8'h31};
    fb = '{8'h02, 8'h03, 8'h04, 8'h05};
    fo = '{2'b00, 2'b01, 2'b00, 2'b01};
    fr = '{8'h03, 8'h0E, 8'h25, 8'h2C};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.rspv", 32'(rsp_valid), 32'd0);
    chk("rst.rspd", 32'(rsp_data), 32'd0);
    chk("rst.cnt", 32'(op_count), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(0, 8'h12, 8'h34, 2'b00, 8'h46, "basic");
    run_op(2, 8'hFF, 8'h01, 2'b00, 8'h00, "addwrap");
    run_op(1, 8'h00, 8'h01, 2'b01, 8'hFF, "subwrap");
    run_op(3, 8'h55, 8'h11, 2'b10, 8'h00, "op10");

    // All valid: last served was 3, so order 0,1,2,3,0
    for (int i = 0; i < 4; i++) begin
      req_a[8*i +: 8] = fa[i];
      req_b[8*i +: 8] = fb[i];
      req_op[2*i +: 2] = fo[i];
    end
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr.rdy", 32'(req_ready), 32'(1 << (k % 4)));
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rr.rspv", 32'(rsp_valid), 32'(1 << (k % 4)));
      chk("rr.rspd", 32'(rsp_data), 32'(fr[k % 4]));
      @(posedge clk);
      #1;
      if (k == 4) req_valid = '0;
      n_ops++;
    end

    // Back-pressure on requester 1 while 2 waits
    req_a[15:8] = 8'h40;
    req_b[15:8] = 8'h02;
    req_op[3:2] = 2'b00;
    req_valid = 4'b0010;
    rsp_ready = 4'b1101;
    @(negedge clk);
    chk("bp.rdy", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1;
    req_a[23:16] = 8'h07;
    req_b[23:16] = 8'h03;
    req_op[5:4] = 2'b01;
    req_valid = 4'b0100;
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp.rspv", 32'(rsp_valid), 32'h2);
      chk("bp.rspd", 32'(rsp_data), 32'h42);
      chk("bp.rdy0", 32'(req_ready), 32'h0);
      @(posedge clk);
    end
    #1 rsp_ready = '1;
    @(negedge clk);
    chk("bp.hold", 32'(rsp_valid), 32'h2);
    @(posedge clk);
    #1;
    n_ops++;
    @(negedge clk);
    chk("bp.next", 32'(req_ready), 32'h4);
    @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    chk("bp2.rspv", 32'(rsp_valid), 32'h4);
    chk("bp2.rspd", 32'(rsp_data), 32'h04);
    @(posedge clk);
    #1;
    n_ops++;

    // Reset during EXEC
    req_a[31:24] = 8'h01;
    req_b[31:24] = 8'h01;
    req_op[7:6] = 2'b00;
    req_valid = 4'b1000;
    @(posedge clk);
    #1 req_valid = 4'b1001;
    @(negedge clk);
    chk("mr.busy_ex", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    n_ops = 0;
    chk("mr.busy", 32'(busy), 32'd0);
    chk("mr.rspv", 32'(rsp_valid), 32'd0);
    chk("mr.rspd", 32'(rsp_data), 32'd0);
    chk("mr.alu", 32'({alu_a, alu_b, 6'd0, alu_opcode}), 32'd0);
    chk("mr.rdy", 32'(req_ready), 32'd0);
    chk("mr.cnt", 32'(op_count), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    req_a[7:0] = 8'h05;
    req_b[7:0] = 8'h06;
    @(negedge clk);
    chk("mr.first", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("mr.nostale", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("mr.rspv2", 32'(rsp_valid), 32'h1);
    chk("mr.rspd2", 32'(rsp_data), 32'h0B);
    @(posedge clk);
    #1;
    n_ops++;

    run_op(1, 8'h80, 8'h80, 2'b00, 8'h00, "post1");
    run_op(2, 8'h10, 8'h20, 2'b01, 8'hF0, "post2");

    @(negedge clk);
`ifdef ALU_ARB_PERF_EN
    chk("cnt3", 32'(op_count), 32'(n_ops));
`else
    chk("cnt0", 32'(op_count), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
